// File: rtl/riscv_pkg.sv
// Shared RV32I encodings used by the writeback stage: result select, load
// funct3 values and the hard-wired zero register.
package riscv_pkg;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_LOAD = 2'd1,
    WB_PC4  = 2'd2,
    WB_RSVD = 2'd3
  } wb_sel_e;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/wb_stage_load_align.sv
// Load data alignment: shifts the raw memory word down to the addressed
// byte/half, sign- or zero-extends it, and flags misaligned LH/LHU/LW.
module load_align
  import riscv_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] data,
  output logic        misalign
);

  logic [31:0] shifted;

  always_comb begin
    shifted  = rdata >> {addr_lo, 3'b000};
    data     = '0;
    misalign = 1'b0;
    case (funct3)
      F3_LB:  data = {{24{shifted[7]}}, shifted[7:0]};
      F3_LBU: data = {24'd0, shifted[7:0]};
      F3_LH: begin
        data     = {{16{shifted[15]}}, shifted[15:0]};
        misalign = addr_lo[0];
      end
      F3_LHU: begin
        data     = {16'd0, shifted[15:0]};
        misalign = addr_lo[0];
      end
      F3_LW: begin
        data     = rdata;
        misalign = (addr_lo != 2'b00);
      end
      // Reserved load encodings return zero without raising a fault
      default: ;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// RV32I writeback stage: stage register, load alignment, result select,
// register-file write port with debug arbitration and bypass source.
// Optional retired-instruction counter enabled by defining WB_INSTRET_EN.
module wb_stage
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_we,
  input  logic [4:0]      in_rd,
  input  logic [1:0]      in_wb_sel,
  input  logic [2:0]      in_funct3,
  input  logic [1:0]      in_addr_lo,
  input  logic [XLEN-1:0] in_alu_result,
  input  logic [XLEN-1:0] in_pc_plus4,
  input  logic [XLEN-1:0] in_mem_rdata,
  input  logic            dbg_valid,
  output logic            dbg_ready,
  input  logic [4:0]      dbg_rd,
  input  logic [XLEN-1:0] dbg_wd,
  output logic            rf_we,
  output logic [4:0]      rf_rd,
  output logic [XLEN-1:0] rf_wd,
  output logic            byp_valid,
  output logic [4:0]      byp_rd,
  output logic [XLEN-1:0] byp_data,
  output logic            retire,
`ifdef WB_INSTRET_EN
  output logic [63:0]     instret,
`endif
  output logic            load_misalign
);

  logic            v_q, v_d;
  logic            we_q, we_d;
  logic [4:0]      rd_q, rd_d;
  wb_sel_e         wb_sel_q, wb_sel_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [1:0]      addr_lo_q, addr_lo_d;
  logic [XLEN-1:0] alu_q, alu_d;
  logic [XLEN-1:0] pc4_q, pc4_d;
  logic [XLEN-1:0] rdata_q, rdata_d;

  logic [XLEN-1:0] ld_data;
  logic            ld_misalign;
  logic [XLEN-1:0] result;
  logic            misalign;
  logic            wr_pipe;

  assign in_ready = !rst;

  always_comb begin
    v_d       = in_valid;
    we_d      = in_we;
    rd_d      = in_rd;
    wb_sel_d  = wb_sel_e'(in_wb_sel);
    funct3_d  = in_funct3;
    addr_lo_d = in_addr_lo;
    alu_d     = in_alu_result;
    pc4_d     = in_pc_plus4;
    rdata_d   = in_mem_rdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q       <= 1'b0;
      we_q      <= 1'b0;
      rd_q      <= '0;
      wb_sel_q  <= WB_ALU;
      funct3_q  <= '0;
      addr_lo_q <= '0;
      alu_q     <= '0;
      pc4_q     <= '0;
      rdata_q   <= '0;
    end else begin
      v_q       <= v_d;
      we_q      <= we_d;
      rd_q      <= rd_d;
      wb_sel_q  <= wb_sel_d;
      funct3_q  <= funct3_d;
      addr_lo_q <= addr_lo_d;
      alu_q     <= alu_d;
      pc4_q     <= pc4_d;
      rdata_q   <= rdata_d;
    end
  end

  load_align u_load_align (
    .rdata    (rdata_q),
    .addr_lo  (addr_lo_q),
    .funct3   (funct3_q),
    .data     (ld_data),
    .misalign (ld_misalign)
  );

  // Every qualifier is gated by rst so a held instruction is dropped the
  // moment reset rises, before the stage register itself is cleared.
  always_comb begin
    case (wb_sel_q)
      WB_LOAD: result = ld_data;
      WB_PC4:  result = pc4_q;
      default: result = alu_q;
    endcase
    misalign  = !rst && v_q && (wb_sel_q == WB_LOAD) && ld_misalign;
    wr_pipe   = !rst && v_q && we_q && (rd_q != REG_ZERO) && !misalign;
    retire    = !rst && v_q && !misalign;
    dbg_ready = !rst && dbg_valid && !wr_pipe;
  end

  assign load_misalign = misalign;
  assign byp_valid     = wr_pipe;
  assign byp_rd        = rd_q;
  assign byp_data      = result;

  always_comb begin
    rf_we = 1'b0;
    rf_rd = '0;
    rf_wd = '0;
    if (wr_pipe) begin
      rf_we = 1'b1;
      rf_rd = rd_q;
      rf_wd = result;
    end else if (dbg_ready) begin
      rf_we = (dbg_rd != REG_ZERO);
      rf_rd = dbg_rd;
      rf_wd = dbg_wd;
    end
  end

`ifdef WB_INSTRET_EN
  logic [63:0] instret_q, instret_d;

  always_comb begin
    instret_d = instret_q + 64'(retire);
  end

  always_ff @(posedge clk) begin
    if (rst) instret_q <= '0;
    else     instret_q <= instret_d;
  end

  assign instret = instret_q;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage; covers WB_INSTRET_EN when defined.
module tb_wb_stage;
  import riscv_pkg::*;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_we;
  logic [4:0]  in_rd;
  logic [1:0]  in_wb_sel;
  logic [2:0]  in_funct3;
  logic [1:0]  in_addr_lo;
  logic [31:0] in_alu_result;
  logic [31:0] in_pc_plus4;
  logic [31:0] in_mem_rdata;
  logic        dbg_valid;
  logic        dbg_ready;
  logic [4:0]  dbg_rd;
  logic [31:0] dbg_wd;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wd;
  logic        byp_valid;
  logic [4:0]  byp_rd;
  logic [31:0] byp_data;
  logic        retire;
  logic        load_misalign;
`ifdef WB_INSTRET_EN
  logic [63:0] instret;
`endif

  int unsigned n_chk;
  int unsigned n_pass;

  wb_stage #(.XLEN(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_we         (in_we),
    .in_rd         (in_rd),
    .in_wb_sel     (in_wb_sel),
    .in_funct3     (in_funct3),
    .in_addr_lo    (in_addr_lo),
    .in_alu_result (in_alu_result),
    .in_pc_plus4   (in_pc_plus4),
    .in_mem_rdata  (in_mem_rdata),
    .dbg_valid     (dbg_valid),
    .dbg_ready     (dbg_ready),
    .dbg_rd        (dbg_rd),
    .dbg_wd        (dbg_wd),
    .rf_we         (rf_we),
    .rf_rd         (rf_rd),
    .rf_wd         (rf_wd),
    .byp_valid     (byp_valid),
    .byp_rd        (byp_rd),
    .byp_data      (byp_data),
    .retire        (retire),
`ifdef WB_INSTRET_EN
    .instret       (instret),
`endif
    .load_misalign (load_misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic check_port(input string tag, input logic we, input logic [4:0] rd,
                            input logic [31:0] wd);
    check({tag, "_we"}, 64'(rf_we), 64'(we));
    check({tag, "_rd"}, 64'(rf_rd), 64'(rd));
    check({tag, "_wd"}, 64'(rf_wd), 64'(wd));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one instruction for a single edge, then samples 1 time unit later.
  task automatic issue(input logic we, input logic [4:0] rd, input logic [1:0] sel,
                       input logic [2:0] f3, input logic [1:0] alo, input logic [31:0] alu,
                       input logic [31:0] pc4, input logic [31:0] rdata);
    in_valid      = 1'b1;
    in_we         = we;
    in_rd         = rd;
    in_wb_sel     = sel;
    in_funct3     = f3;
    in_addr_lo    = alo;
    in_alu_result = alu;
    in_pc_plus4   = pc4;
    in_mem_rdata  = rdata;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic load(input logic [2:0] f3, input logic [1:0] alo);
    issue(1'b1, 5'd3, 2'd1, f3, alo, 32'h0BAD_0BAD, 32'h0, 32'h80FF_7F01);
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    rst = 1'b1;
    in_valid = 1'b1; in_we = 1'b1; in_rd = 5'd9; in_wb_sel = 2'd0; in_funct3 = 3'd0;
    in_addr_lo = 2'd0; in_alu_result = 32'h1111_1111; in_pc_plus4 = '0; in_mem_rdata = '0;
    dbg_valid = 1'b1; dbg_rd = 5'd7; dbg_wd = 32'hDEAD_BEEF;

    // Reset: nothing may leak out even with requests pending
    tick();
    tick();
    check("rst_in_ready", 64'(in_ready), 64'h0);
    check("rst_dbg_ready", 64'(dbg_ready), 64'h0);
    check("rst_retire", 64'(retire), 64'h0);
    check_port("rst_port", 1'b0, 5'd0, 32'h0);
`ifdef WB_INSTRET_EN
    check("rst_instret", instret, 64'h0);
`endif
    rst = 1'b0;
    in_valid = 1'b0;
    dbg_valid = 1'b0;
    tick();
    check("post_rst_in_ready", 64'(in_ready), 64'h1);
    check("post_rst_retire", 64'(retire), 64'h0);
    check("post_rst_byp_valid", 64'(byp_valid), 64'h0);

    // ALU write
    issue(1'b1, 5'd5, 2'd0, 3'd0, 2'd0, 32'h1234_5678, 32'h0, 32'h0);
    check_port("alu", 1'b1, 5'd5, 32'h1234_5678);
    check("alu_byp_valid", 64'(byp_valid), 64'h1);
    check("alu_byp_rd", 64'(byp_rd), 64'd5);
    check("alu_byp_data", 64'(byp_data), 64'h1234_5678);
    check("alu_retire", 64'(retire), 64'h1);

    // Loads from word 0x80FF_7F01
    load(F3_LB, 2'd2);  check_port("lb2", 1'b1, 5'd3, 32'hFFFF_FFFF);
    load(F3_LBU, 2'd3); check_port("lbu3", 1'b1, 5'd3, 32'h0000_0080);
    load(F3_LH, 2'd0);  check_port("lh0", 1'b1, 5'd3, 32'h0000_7F01);
    load(F3_LHU, 2'd2); check_port("lhu2", 1'b1, 5'd3, 32'h0000_80FF);
    load(F3_LH, 2'd2);  check_port("lh2", 1'b1, 5'd3, 32'hFFFF_80FF);
    load(F3_LB, 2'd0);  check_port("lb0", 1'b1, 5'd3, 32'h0000_0001);
    load(F3_LW, 2'd0);  check_port("lw0", 1'b1, 5'd3, 32'h80FF_7F01);
    load(3'd3, 2'd0);
    check_port("f3_inv", 1'b1, 5'd3, 32'h0);
    check("f3_inv_misalign", 64'(load_misalign), 64'h0);

    // Misaligned loads
    load(F3_LW, 2'd1);
    check("lw1_misalign", 64'(load_misalign), 64'h1);
    check("lw1_retire", 64'(retire), 64'h0);
    check("lw1_byp_valid", 64'(byp_valid), 64'h0);
    check_port("lw1", 1'b0, 5'd0, 32'h0);
    load(F3_LH, 2'd3);
    check("lh3_misalign", 64'(load_misalign), 64'h1);
    check("lh3_retire", 64'(retire), 64'h0);
    check_port("lh3", 1'b0, 5'd0, 32'h0);
    tick();
    check("misalign_pulse", 64'(load_misalign), 64'h0);

    // x0, we=0, JAL link, reserved select
    issue(1'b1, 5'd0, 2'd0, 3'd0, 2'd0, 32'h5555_AAAA, 32'h0, 32'h0);
    check("x0_rf_we", 64'(rf_we), 64'h0);
    check("x0_retire", 64'(retire), 64'h1);
    issue(1'b0, 5'd4, 2'd0, 3'd0, 2'd0, 32'h5555_AAAA, 32'h0, 32'h0);
    check("nowe_rf_we", 64'(rf_we), 64'h0);
    check("nowe_retire", 64'(retire), 64'h1);
    issue(1'b1, 5'd1, 2'd2, 3'd0, 2'd0, 32'hFFFF_0000, 32'h0000_0104, 32'h0);
    check_port("jal", 1'b1, 5'd1, 32'h0000_0104);
    issue(1'b1, 5'd2, 2'd3, 3'd0, 2'd0, 32'h0000_00AB, 32'h0000_0200, 32'h0);
    check_port("rsvd_sel", 1'b1, 5'd2, 32'h0000_00AB);

    // Debug held off under back-to-back writes to the same rd
    dbg_valid = 1'b1; dbg_rd = 5'd7; dbg_wd = 32'hDEAD_BEEF;
    issue(1'b1, 5'd8, 2'd0, 3'd0, 2'd0, 32'h0000_0001, 32'h0, 32'h0);
    check("dbg_hold0", 64'(dbg_ready), 64'h0);
    check_port("b2b0", 1'b1, 5'd8, 32'h0000_0001);
    issue(1'b1, 5'd8, 2'd0, 3'd0, 2'd0, 32'h0000_0002, 32'h0, 32'h0);
    check("dbg_hold1", 64'(dbg_ready), 64'h0);
    check_port("b2b1", 1'b1, 5'd8, 32'h0000_0002);
    issue(1'b1, 5'd8, 2'd0, 3'd0, 2'd0, 32'h0000_0003, 32'h0, 32'h0);
    check("dbg_hold2", 64'(dbg_ready), 64'h0);
    check_port("b2b2", 1'b1, 5'd8, 32'h0000_0003);
    tick();
    check("dbg_grant", 64'(dbg_ready), 64'h1);
    check_port("dbg_wr", 1'b1, 5'd7, 32'hDEAD_BEEF);
    dbg_rd = 5'd0;
    #1;
    check("dbg_x0_ready", 64'(dbg_ready), 64'h1);
    check("dbg_x0_rf_we", 64'(rf_we), 64'h0);
    // A faulting load does not block debug
    dbg_rd = 5'd12; dbg_wd = 32'h0000_0055;
    load(F3_LW, 2'd2);
    check("dbg_misalign_ready", 64'(dbg_ready), 64'h1);
    check_port("dbg_misalign", 1'b1, 5'd12, 32'h0000_0055);
    dbg_valid = 1'b0;
    #1;
    check("dbg_idle_ready", 64'(dbg_ready), 64'h0);
    check_port("idle", 1'b0, 5'd0, 32'h0);

    // Reset mid-flight discards the held write
    issue(1'b1, 5'd6, 2'd0, 3'd0, 2'd0, 32'hAAAA_5555, 32'h0, 32'h0);
    rst = 1'b1;
    #1;
    check("midrst_rf_we", 64'(rf_we), 64'h0);
    check("midrst_byp_valid", 64'(byp_valid), 64'h0);
    check("midrst_retire", 64'(retire), 64'h0);
    check("midrst_in_ready", 64'(in_ready), 64'h0);
    tick();
`ifdef WB_INSTRET_EN
    check("midrst_instret", instret, 64'h0);
`endif
    rst = 1'b0;
    tick();
    check("after_rst_rf_we", 64'(rf_we), 64'h0);
    check("after_rst_retire", 64'(retire), 64'h0);

    // Three retiring instructions
    issue(1'b1, 5'd10, 2'd0, 3'd0, 2'd0, 32'h1, 32'h0, 32'h0);
    issue(1'b0, 5'd11, 2'd0, 3'd0, 2'd0, 32'h2, 32'h0, 32'h0);
    issue(1'b1, 5'd0, 2'd0, 3'd0, 2'd0, 32'h3, 32'h0, 32'h0);
`ifdef WB_INSTRET_EN
    check("instret_2", instret, 64'd2);
`endif
    tick();
    check("final_retire", 64'(retire), 64'h0);
`ifdef WB_INSTRET_EN
    check("instret_3", instret, 64'd3);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
